err_rate_monitor: RTL and testbench
===================================

ERR_RATE_MONITOR -- requirements
Module: err_rate_monitor

Interface
REQ-001 SHALL have parameter WIN_W, default 8, width of window length and all counters.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a measurement window.
REQ-005 SHALL have port win_len  input  WIN_W  number of samples in the window; sampled on accepted start.
REQ-006 SHALL have port err_thresh  input  WIN_W  alarm threshold on error count; sampled on accepted start.
REQ-007 SHALL have port in_valid  input  1  upstream comparator flag is valid this cycle.
REQ-008 SHALL have port in_err  input  1  comparator output of the 4-bit approximate adder stage (1 = error beyond tolerance).
REQ-009 SHALL have port in_ready  output  1  monitor accepts a sample this cycle.
REQ-010 SHALL have port busy  output  1  window in progress.
REQ-011 SHALL have port done  output  1  results valid; level, held until next accepted start or reset.
REQ-012 SHALL have port err_count  output  WIN_W  errors counted in current/last window.
REQ-013 SHALL have port sample_count  output  WIN_W  samples accepted in current/last window.
REQ-014 SHALL have port max_burst  output  WIN_W  longest run of consecutive accepted erroneous samples.
REQ-015 SHALL have port first_err_idx  output  WIN_W  zero-based index of first erroneous sample; valid when first_err_vld=1.
REQ-016 SHALL have port first_err_vld  output  1  at least one error seen in window.
REQ-017 SHALL have port alarm  output  1  err_count >= latched err_thresh at window end; valid with done.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE, in_ready=1 only in RUN.
REQ-019 SHALL accept start in IDLE or DONE; start in RUN SHALL be ignored.
REQ-020 On accepted start: latch win_len/err_thresh, clear all counters, first_err_vld, alarm, burst registers; next state RUN, or DONE if win_len=0 (alarm = (err_thresh==0)).
REQ-021 A sample is accepted when in_valid & in_ready; in_err ignored otherwise.
REQ-022 Per accepted sample: sample_count+1; if in_err, err_count+1 and current run+1, else current run cleared to 0.
REQ-023 max_burst SHALL update the same cycle as current run: max_burst = max(max_burst, run+1) when in_err=1.
REQ-024 On first accepted in_err=1, first_err_idx SHALL capture sample_count value before increment and first_err_vld set; later errors SHALL not change it.
REQ-025 When accepted sample makes sample_count equal latched win_len, next state SHALL be DONE; alarm registered on that same edge from updated err_count.
REQ-026 Outputs SHALL be registered; results visible the cycle after last accepted sample (latency 1).
REQ-027 Counters SHALL never wrap; win_len bounds sample_count and err_count (max 2^WIN_W-1).
REQ-028 In DONE, all result outputs SHALL hold stable; in_valid SHALL have no effect.
REQ-029 Changes to win_len/err_thresh during RUN SHALL have no effect on the current window.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE and all outputs to 0 (in_ready=0, busy=0, done=0, alarm=0, all counts 0, first_err_vld=0), independent of clk.
REQ-031 Reset asserted mid-window SHALL discard partial results; after release, block waits in IDLE for start.

Verification
REQ-032 win_len=4, thresh=2, in_err=0,1,1,0 contiguous -> done 1 cycle after 4th sample; err_count=2, sample_count=4, max_burst=2, first_err_idx=1, alarm=1.
REQ-033 win_len=5, thresh=3, in_err=1,0,1,1,0 with in_valid gaps -> gaps not counted; err_count=3, max_burst=2, first_err_idx=0, alarm=1.
REQ-034 win_len=3, thresh=1, all in_err=0 -> err_count=0, first_err_vld=0, max_burst=0, alarm=0; start during RUN ignored.
REQ-035 win_len=0, thresh=0 start -> DONE next cycle, sample_count=0, alarm=1; win_len=0, thresh=1 -> alarm=0.
REQ-036 rst pulse after 2 of 8 samples -> all outputs 0 asynchronously; new start win_len=2 counts from 0.
REQ-037 win_len=255, all in_err=1 -> err_count=255, max_burst=255, no wrap; restart from DONE clears results.

Source files
------------

// File: rtl/err_rate_monitor.sv
// Windowed error-rate monitor for the approximate-adder comparator stream.
// Counts samples and errors, tracks the longest error burst and the first error index, and raises an alarm against a threshold.
module err_rate_monitor #(
    parameter int WIN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic [WIN_W-1:0] err_thresh,
    input  logic             in_valid,
    input  logic             in_err,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [WIN_W-1:0] err_count,
    output logic [WIN_W-1:0] sample_count,
    output logic [WIN_W-1:0] max_burst,
    output logic [WIN_W-1:0] first_err_idx,
    output logic             first_err_vld,
    output logic             alarm
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIN_W-1:0] len_q, len_d;
    logic [WIN_W-1:0] thr_q, thr_d;
    logic [WIN_W-1:0] err_q, err_d;
    logic [WIN_W-1:0] smp_q, smp_d;
    logic [WIN_W-1:0] run_q, run_d;
    logic [WIN_W-1:0] max_q, max_d;
    logic [WIN_W-1:0] fidx_q, fidx_d;
    logic             fvld_q, fvld_d;
    logic             alarm_q, alarm_d;

    logic [WIN_W-1:0] smp_inc, err_inc, run_inc;

    // Increments cannot wrap: every counter is bounded by the latched window length.
    assign smp_inc = smp_q + WIN_W'(1);
    assign err_inc = err_q + {{(WIN_W-1){1'b0}}, in_err};
    assign run_inc = run_q + WIN_W'(1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        thr_d   = thr_q;
        err_d   = err_q;
        smp_d   = smp_q;
        run_d   = run_q;
        max_d   = max_q;
        fidx_d  = fidx_q;
        fvld_d  = fvld_q;
        alarm_d = alarm_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    len_d   = win_len;
                    thr_d   = err_thresh;
                    err_d   = '0;
                    smp_d   = '0;
                    run_d   = '0;
                    max_d   = '0;
                    fidx_d  = '0;
                    fvld_d  = 1'b0;
                    alarm_d = 1'b0;
                    // An empty window completes immediately with zero errors.
                    if (win_len == '0) begin
                        state_d = S_DONE;
                        alarm_d = (err_thresh == '0);
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (in_valid) begin
                    smp_d = smp_inc;
                    err_d = err_inc;
                    if (in_err) begin
                        run_d = run_inc;
                        if (run_inc > max_q) max_d = run_inc;
                        if (!fvld_q) begin
                            fidx_d = smp_q;
                            fvld_d = 1'b1;
                        end
                    end else begin
                        run_d = '0;
                    end
                    if (smp_inc == len_q) begin
                        state_d = S_DONE;
                        alarm_d = (err_inc >= thr_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            thr_q   <= '0;
            err_q   <= '0;
            smp_q   <= '0;
            run_q   <= '0;
            max_q   <= '0;
            fidx_q  <= '0;
            fvld_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            thr_q   <= thr_d;
            err_q   <= err_d;
            smp_q   <= smp_d;
            run_q   <= run_d;
            max_q   <= max_d;
            fidx_q  <= fidx_d;
            fvld_q  <= fvld_d;
            alarm_q <= alarm_d;
        end
    end

    assign in_ready      = (state_q == S_RUN);
    assign busy          = (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign err_count     = err_q;
    assign sample_count  = smp_q;
    assign max_burst     = max_q;
    assign first_err_idx = fidx_q;
    assign first_err_vld = fvld_q;
    assign alarm         = alarm_q;

endmodule

// File: tb/tb_err_rate_monitor.sv
// Directed bench for err_rate_monitor; each scenario checks the packed result vector against hand-derived values.
module tb_err_rate_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] win_len;
    logic [7:0] err_thresh;
    logic       in_valid;
    logic       in_err;
    logic       in_ready, busy, done, first_err_vld, alarm;
    logic [7:0] err_count, sample_count, max_burst, first_err_idx;

    int nchk = 0;
    int nerr = 0;

    // {done, busy, in_ready, alarm, first_err_vld, err_count, sample_count, max_burst, first_err_idx}
    logic [36:0] res;
    logic [36:0] exp_v;
    assign res = {done, busy, in_ready, alarm, first_err_vld,
                  err_count, sample_count, max_burst, first_err_idx};

    err_rate_monitor #(.WIN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len),
        .err_thresh(err_thresh), .in_valid(in_valid), .in_err(in_err),
        .in_ready(in_ready), .busy(busy), .done(done),
        .err_count(err_count), .sample_count(sample_count),
        .max_burst(max_burst), .first_err_idx(first_err_idx),
        .first_err_vld(first_err_vld), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] len, input logic [7:0] thr);
        start = 1'b1; win_len = len; err_thresh = thr;
        cyc();
        start = 1'b0;
    endtask

    task automatic sample(input logic v, input logic e);
        in_valid = v; in_err = e;
        cyc();
        in_valid = 1'b0; in_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; win_len = '0; err_thresh = '0;
        in_valid = 1'b0; in_err = 1'b0;
        #2;
        exp_v = '0;
        nchk++;
        if (res !== exp_v) begin nerr++; $display("FAIL reset_async: got %h expected %h", res, exp_v); end
        cyc(); cyc();
        rst = 1'b0;
        in_valid = 1'b1; in_err = 1'b1;
        cyc();
        in_valid = 1'b0; in_err = 1'b0;
        nchk++;
        if (res !== exp_v) begin nerr++; $display("FAIL reset_idle: got %h expected %h", res, exp_v); end
    endtask

    task automatic test_basic();
        do_start(8'd4, 8'd2);
        exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0};
        nchk++;
        if (res !== exp_v) begin nerr++; $display("FAIL basic_run: got %h expected %h", res, exp_v); end
        sample(1, 0); sample(1, 1); sample(1, 1);
        exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 8'd3, 8'd2, 8'd1};
        nchk++;
        if (res !== exp_v) begin nerr++; $display("FAIL basic_mid: got %h expected %h", res, exp_v); end
        sample(1, 0);
        exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 8'd4, 8'd2, 8'd1};
        nchk++;
        if (res !== exp_v) begin nerr++; $display("FAIL basic_done: got %h expected %h", res, exp_v); end
    endtask

    task automatic test_gaps();
        do_start(8'd5, 8'd3);
        exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0};
        nchk++;
        if (res !== exp_v) begin nerr++; $display("FAIL gaps_restart_clear: got %h expected %h", res, exp_v); end
        // Window parameters changed mid-run must not shorten the window.
        win_len = 8'd1; err_thresh = 8'd9;
        sample(1, 1); sample(0, 1); sample(1, 0); sample(1, 1);
        sample(0, 1); sample(0, 1); sample(1, 1);
        exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3, 8'd4, 8'd2, 8'd0};
        nchk++;
        if (res !== exp_v) begin nerr++; $display("FAIL gaps_mid: got %h expected %h", res, exp_v); end
        sample(1, 0);
        exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3, 8'd5, 8'd2, 8'd0};
        nchk++;
        if (res !== exp_v) begin nerr++; $display("FAIL gaps_done: got %h expected %h", res, exp_v); end
    endtask

    task automatic test_no_err();
        do_start(8'd3, 8'd1);
        sample(1, 0);
        start = 1'b1; win_len = 8'd1; err_thresh = 8'd0;
        sample(1, 0);
        start = 1'b0;
        exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd2, 8'd0, 8'd0};
        nchk++;
        if (res !== exp_v) begin nerr++; $display("FAIL noerr_start_ignored: got %h expected %h", res, exp_v); end
        sample(1, 0);
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd3, 8'd0, 8'd0};
        nchk++;
        if (res !== exp_v) begin nerr++; $display("FAIL noerr_done: got %h expected %h", res, exp_v); end
        sample(1, 1); sample(1, 1); sample(1, 1);
        nchk++;
        if (res !== exp_v) begin nerr++; $display("FAIL noerr_hold: got %h expected %h", res, exp_v); end
    endtask

    task automatic test_zero_len();
        do_start(8'd0, 8'd0);
        exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0};
        nchk++;
        if (res !== exp_v) begin nerr++; $display("FAIL zero_thr0: got %h expected %h", res, exp_v); end
        do_start(8'd0, 8'd1);
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0};
        nchk++;
        if (res !== exp_v) begin nerr++; $display("FAIL zero_thr1: got %h expected %h", res, exp_v); end
    endtask

    task automatic test_reset_mid();
        do_start(8'd8, 8'd1);
        sample(1, 1); sample(1, 1);
        exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 8'd2, 8'd2, 8'd0};
        nchk++;
        if (res !== exp_v) begin nerr++; $display("FAIL rstmid_pre: got %h expected %h", res, exp_v); end
        #2 rst = 1'b1;
        #1;
        exp_v = '0;
        nchk++;
        if (res !== exp_v) begin nerr++; $display("FAIL rstmid_async: got %h expected %h", res, exp_v); end
        cyc();
        rst = 1'b0;
        sample(1, 1);
        nchk++;
        if (res !== exp_v) begin nerr++; $display("FAIL rstmid_idle: got %h expected %h", res, exp_v); end
        do_start(8'd2, 8'd1);
        sample(1, 0); sample(1, 1);
        exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 8'd2, 8'd1, 8'd1};
        nchk++;
        if (res !== exp_v) begin nerr++; $display("FAIL rstmid_new: got %h expected %h", res, exp_v); end
    endtask

    task automatic test_long();
        do_start(8'd255, 8'd255);
        for (int i = 0; i < 254; i++) sample(1, 1);
        exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd254, 8'd254, 8'd254, 8'd0};
        nchk++;
        if (res !== exp_v) begin nerr++; $display("FAIL long_254: got %h expected %h", res, exp_v); end
        sample(1, 1);
        exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255, 8'd0};
        nchk++;
        if (res !== exp_v) begin nerr++; $display("FAIL long_done: got %h expected %h", res, exp_v); end
        sample(1, 1); sample(1, 1);
        nchk++;
        if (res !== exp_v) begin nerr++; $display("FAIL long_nowrap: got %h expected %h", res, exp_v); end
        do_start(8'd2, 8'd1);
        exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0};
        nchk++;
        if (res !== exp_v) begin nerr++; $display("FAIL long_restart: got %h expected %h", res, exp_v); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_no_err();
        test_zero_len();
        test_reset_mid();
        test_long();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
